// File: rtl/dot_pkg.sv
// Shared types and constants for the cascaded dot-product driver and its datapath wrapper.
package dot_pkg;

    localparam int DOT_WIDTH = 8;
    localparam int DOT_LAT   = 4;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } dot_state_e;

    typedef struct packed {
        logic [DOT_WIDTH-1:0] bias;
        logic [DOT_WIDTH-1:0] a;
        logic [DOT_WIDTH-1:0] b;
        logic [DOT_WIDTH-1:0] c;
        logic [DOT_WIDTH-1:0] d;
    } dot_ops_t;

endpackage

// File: rtl/dot_result_fifo.sv
// Circular result FIFO with occupancy output; head entry is presented directly (no bypass).
module dot_result_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [OW-1:0]    occ
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]               occ_q, occ_d;
    logic                        do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && (occ_q != '0);
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        occ_d = occ_q + OW'(push) - OW'(do_pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign valid = (occ_q != '0);
    assign data  = mem_q[rd_ptr_q];
    assign occ   = occ_q;

    // Upstream credits must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && (occ_q == OW'(DEPTH))));

endmodule

// File: rtl/dot_driver.sv
// Issues operand sets into the fixed-latency dot-product datapath and collects results
// into a credit-protected FIFO; sequences the datapath's synchronous reset after reset_n.
module dot_driver
    import dot_pkg::*;
#(
    parameter int WIDTH = DOT_WIDTH,
    parameter int LAT   = DOT_LAT,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bias,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    output logic             dot_reset,
    output logic             dot_en,
    output logic [WIDTH-1:0] dot_bias,
    output logic [WIDTH-1:0] dot_a,
    output logic [WIDTH-1:0] dot_b,
    output logic [WIDTH-1:0] dot_c,
    output logic [WIDTH-1:0] dot_d,
    input  logic [WIDTH-1:0] dot_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LAT + 1);

    if (DEPTH < LAT) begin : g_depth_check
        $error("dot_driver: DEPTH (%0d) must be >= LAT (%0d)", DEPTH, LAT);
    end

    dot_state_e     state_q, state_d;
    logic [CW-1:0]  flush_cnt_q, flush_cnt_d;
    logic           dot_reset_q, dot_reset_d;
    logic [LAT-1:0] tag_q, tag_d;
    logic [IW-1:0]  infl;
    logic [OW-1:0]  occ;
    logic           accept;
    int             credits_used;

    // Hold the datapath in reset for LAT enabled edges so stale stages are purged.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        dot_reset_d = dot_reset_q;
        if (state_q == FLUSH) begin
            if (flush_cnt_q == CW'(LAT - 1)) begin
                state_d     = RUN;
                dot_reset_d = 1'b0;
            end else begin
                flush_cnt_d = flush_cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        infl = '0;
        for (int i = 0; i < LAT; i++) begin
            infl = infl + IW'(tag_q[i]);
        end
    end

    // Every in-flight tag reserves a FIFO slot, so the pipeline never has to stall.
    always_comb begin
        credits_used = int'(occ) + int'(infl);
        in_ready     = (state_q == RUN) && (credits_used < DEPTH);
        accept       = in_valid && in_ready;
        tag_d        = LAT'({tag_q, accept});
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FLUSH;
            flush_cnt_q <= '0;
            dot_reset_q <= 1'b1;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            dot_reset_q <= dot_reset_d;
            tag_q       <= tag_d;
        end
    end

    assign dot_reset = dot_reset_q;
    assign dot_en    = 1'b1;
    assign dot_bias  = accept ? in_bias : '0;
    assign dot_a     = accept ? in_a    : '0;
    assign dot_b     = accept ? in_b    : '0;
    assign dot_c     = accept ? in_c    : '0;
    assign dot_d     = accept ? in_d    : '0;

    dot_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (tag_q[LAT-1]),
        .push_data (dot_y),
        .pop       (out_ready),
        .valid     (out_valid),
        .data      (out_y),
        .occ       (occ)
    );

endmodule

// File: tb/tb_dot_driver.sv
// Bench for dot_driver: behavioural datapath, expected-result queue, randomized traffic.
module tb_dot_driver;
    import dot_pkg::*;

    localparam int W     = DOT_WIDTH;
    localparam int LAT   = DOT_LAT;
    localparam int DEPTH = 4;

    logic         clock = 1'b0;
    logic         reset_n, in_valid, in_ready, out_valid, out_ready;
    logic         dot_reset, dot_en;
    logic [W-1:0] in_bias, in_a, in_b, in_c, in_d;
    logic [W-1:0] dot_bias, dot_a, dot_b, dot_c, dot_d, dot_y, out_y;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_out   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] dp_pipe[LAT];
    logic         hold_v;
    logic [W-1:0] hold_y;
    bit           rnd_run;

    always #5 clock = ~clock;

    dot_driver #(.WIDTH(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_bias(in_bias), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .dot_reset(dot_reset), .dot_en(dot_en),
        .dot_bias(dot_bias), .dot_a(dot_a), .dot_b(dot_b), .dot_c(dot_c), .dot_d(dot_d),
        .dot_y(dot_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] dot_ref(input dot_ops_t o);
        int s;
        s = int'($signed(o.a)) * int'($signed(o.b)) + int'($signed(o.bias))
          + int'($signed(o.c)) * int'($signed(o.d));
        return s[W-1:0];
    endfunction

    function automatic dot_ops_t rand_op();
        dot_ops_t o;
        o = {W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
             W'($urandom_range(0, 255)), W'($urandom_range(0, 255))};
        return o;
    endfunction

    // Behavioural datapath: LAT enabled stages with synchronous reset.
    always @(posedge clock) begin
        if (dot_reset) begin
            for (int i = 0; i < LAT; i++) dp_pipe[i] <= '0;
        end else if (dot_en) begin
            dp_pipe[0] <= dot_ref({dot_bias, dot_a, dot_b, dot_c, dot_d});
            for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
        end
    end
    assign dot_y = dp_pipe[LAT-1];

    // Output monitor: in-order scoreboard plus hold-while-stalled check.
    always @(posedge clock) begin
        if (!reset_n) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_y", 32'(out_y), 32'(hold_y));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) chk("spurious_out", 32'(out_y), 32'hFFFF_FFFF);
                else chk("out_y", 32'(out_y), 32'(exp_q.pop_front()));
            end
            hold_v <= out_valid && !out_ready;
            hold_y <= out_y;
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic issue(input dot_ops_t op);
        int k;
        k = 0;
        {in_bias, in_a, in_b, in_c, in_d} = op;
        in_valid = 1'b1;
        while (!in_ready && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        exp_q.push_back(dot_ref(op));
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 2000) begin
            @(negedge clock);
            k++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rst_cnt, first_rdy, ov_seen, n, base;
        dot_ops_t op;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        {in_bias, in_a, in_b, in_c, in_d} = '0;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_dot_reset", 32'(dot_reset), 32'd1);
        chk("rst_dot_en", 32'(dot_en), 32'd1);
        chk("rst_dot_a", 32'(dot_a), 32'd0);

        // Reset release: count flush cycles and when credits open.
        reset_n = 1'b1;
        rst_cnt = 0; first_rdy = -1; ov_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (dot_reset) rst_cnt++;
            if (in_ready && first_rdy < 0) first_rdy = k;
            if (out_valid) ov_seen = 1;
            @(negedge clock);
        end
        chk("flush_cycles", 32'(rst_cnt), 32'(LAT));
        chk("first_ready", 32'(first_rdy), 32'(LAT));
        chk("flush_no_out", 32'(ov_seen), 32'd0);

        // Single op, latency from accept edge to out_valid.
        out_ready = 1'b1;
        op = '{bias: 8'd3, a: 8'd2, b: 8'd5, c: 8'hFF, d: 8'd4};
        issue(op);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("single_latency", 32'(n), 32'(LAT));
        chk("single_y", 32'(out_y), 32'h09);
        wait_drain();

        // Wrap-around: 127*127 + 127 + 127*127 = 32385, mod 256 = 0x81.
        op = '{bias: 8'h7F, a: 8'h7F, b: 8'h7F, c: 8'h7F, d: 8'h7F};
        issue(op);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("wrap_y", 32'(out_y), 32'h81);
        wait_drain();

        // Back-pressure: 10 ops with out_ready low until credits run out.
        out_ready = 1'b0;
        base = n_out;
        for (int i = 0; i < DEPTH; i++) issue(rand_op());
        chk("bp_ready_drop", 32'(in_ready), 32'd0);
        repeat (LAT + 2) @(negedge clock);
        chk("bp_ready_held", 32'(in_ready), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        fork
            for (int i = DEPTH; i < 10; i++) issue(rand_op());
            begin
                repeat (8) @(negedge clock);
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_count", 32'(n_out - base), 32'd10);

        // Push and pop on the same edge with two entries queued.
        out_ready = 1'b0;
        issue(rand_op());
        issue(rand_op());
        repeat (LAT + 1) @(negedge clock);
        chk("pp_pre_valid", 32'(out_valid), 32'd1);
        issue(rand_op());
        repeat (LAT - 1) @(negedge clock);
        out_ready = 1'b1;
        base = n_out;
        @(negedge clock);
        out_ready = 1'b0;
        chk("pp_one_pop", 32'(n_out - base), 32'd1);
        chk("pp_valid", 32'(out_valid), 32'd1);
        chk("pp_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        wait_drain();
        chk("pp_count", 32'(n_out - base), 32'd3);

        // Random valid/ready traffic.
        base = n_out;
        rnd_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clock);
                    issue(rand_op());
                end
                rnd_run = 1'b0;
            end
            while (rnd_run) begin
                @(negedge clock);
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = 1'b1;
        wait_drain();
        chk("rnd_count", 32'(n_out - base), 32'd1000);

        // Reset with two results queued and two in flight.
        out_ready = 1'b0;
        issue(rand_op());
        issue(rand_op());
        repeat (LAT + 1) @(negedge clock);
        issue(rand_op());
        issue(rand_op());
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_dot_reset", 32'(dot_reset), 32'd1);
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("mid_rst_reflush", 32'(n), 32'(LAT));
        chk("mid_rst_no_out", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        base = n_out;
        issue('{bias: 8'd1, a: 8'd3, b: 8'd4, c: 8'd0, d: 8'd9});
        wait_drain();
        repeat (LAT + 2) @(negedge clock);
        chk("mid_rst_count", 32'(n_out - base), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
